// File: rtl/stack_push_if.sv
// Request and bus-write signal group for stack_push_unit.
// The master side issues push requests; the slave side is the push unit.
interface stack_push_if;
  logic        start;
  logic [1:0]  len;
  logic [23:0] value;
  logic [15:0] sp_in;
  logic        emu;
  logic        busy;
  logic        bus_write;
  logic [23:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        done;
  logic        sp_write;
  logic [15:0] sp_out;

  modport master (
    output start, len, value, sp_in, emu,
    input  busy, bus_write, bus_addr, bus_wdata, done, sp_write, sp_out
  );

  modport slave (
    input  start, len, value, sp_in, emu,
    output busy, bus_write, bus_addr, bus_wdata, done, sp_write, sp_out
  );
endinterface

// File: rtl/stack_push_unit.sv
// Serializes a 1-3 byte register value onto the data bus as a 65816 stack push,
// MSB first, decrementing SP after each byte; advances only on cpu_en cycles.
module stack_push_unit (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_en,
  stack_push_if.slave   sp_bus
);

  typedef enum logic [1:0] {IDLE, PUSH, FIN} state_t;

  state_t      state;
  logic [23:0] val_q;
  logic [1:0]  cnt_q;
  logic        emu_q;
  logic [15:0] sp_q;

  logic [15:0] start_sp_c;
  logic [15:0] next_sp_c;
  logic [1:0]  next_cnt_c;

  function automatic logic [7:0] pick_byte(input logic [23:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    pick_byte = v[7:0];
      2'd1:    pick_byte = v[15:8];
      default: pick_byte = v[23:16];
    endcase
  endfunction

  // Emulation mode pins the stack to page 1 and wraps within it.
  assign start_sp_c = sp_bus.emu ? {8'h01, sp_bus.sp_in[7:0]} : sp_bus.sp_in;
  assign next_sp_c  = emu_q ? {8'h01, 8'(sp_q[7:0] - 8'd1)} : 16'(sp_q - 16'd1);
  assign next_cnt_c = 2'(cnt_q - 2'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      val_q            <= 24'd0;
      cnt_q            <= 2'd0;
      emu_q            <= 1'b0;
      sp_q             <= 16'd0;
      sp_bus.busy      <= 1'b0;
      sp_bus.bus_write <= 1'b0;
      sp_bus.bus_addr  <= 24'd0;
      sp_bus.bus_wdata <= 8'd0;
      sp_bus.done      <= 1'b0;
      sp_bus.sp_write  <= 1'b0;
      sp_bus.sp_out    <= 16'd0;
    end else if (cpu_en) begin
      case (state)
        // FIN also accepts a start so pushes can run back to back.
        IDLE, FIN: begin
          sp_bus.done     <= 1'b0;
          sp_bus.sp_write <= 1'b0;
          if (sp_bus.start && (sp_bus.len != 2'd0)) begin
            val_q            <= sp_bus.value;
            cnt_q            <= sp_bus.len;
            emu_q            <= sp_bus.emu;
            sp_q             <= start_sp_c;
            sp_bus.busy      <= 1'b1;
            sp_bus.bus_write <= 1'b1;
            sp_bus.bus_addr  <= {8'h00, start_sp_c};
            sp_bus.bus_wdata <= pick_byte(sp_bus.value, 2'(sp_bus.len - 2'd1));
            state            <= PUSH;
          end else begin
            state <= IDLE;
          end
        end
        PUSH: begin
          sp_q  <= next_sp_c;
          cnt_q <= next_cnt_c;
          if (next_cnt_c == 2'd0) begin
            sp_bus.busy      <= 1'b0;
            sp_bus.bus_write <= 1'b0;
            sp_bus.done      <= 1'b1;
            sp_bus.sp_write  <= 1'b1;
            sp_bus.sp_out    <= next_sp_c;
            state            <= FIN;
          end else begin
            sp_bus.bus_addr  <= {8'h00, next_sp_c};
            sp_bus.bus_wdata <= pick_byte(val_q, 2'(next_cnt_c - 2'd1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
